// File: rtl/cpu_run_pkg.sv
// Shared constants for the cpu run controller: FSM encoding, halt codes, SYSTEM opcodes.
package cpu_run_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE     = 2'd0;
  localparam state_t RST_HOLD = 2'd1;
  localparam state_t RUN      = 2'd2;
  localparam state_t DONE     = 2'd3;

  localparam logic [1:0] HALT_NONE   = 2'd0;
  localparam logic [1:0] HALT_ECALL  = 2'd1;
  localparam logic [1:0] HALT_EBREAK = 2'd2;
  localparam logic [1:0] HALT_LOOP   = 2'd3;

  localparam logic [31:0] INSTR_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;

  // Count register: clear wins over enable, hold at all-ones.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count_q <= '0;
    end else if (en && (count_q != '1)) begin
      count_q <= count_q + W'(1);
    end
  end

  assign count = count_q;

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run controller beside the RV32 core: reset sequencing, cycle/retire counting,
// end-of-program detection (ECALL, EBREAK, PC self-loop) and timeout.
module cpu_run_ctrl
  import cpu_run_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned RST_CYCLES  = 1,
  parameter int unsigned MAX_CYCLES  = 24,
  parameter int unsigned LOOP_REPEAT = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [XLEN-1:0]  pc_in,
  input  logic [31:0]      instr_in,
  input  logic             reg_we,
  output logic             cpu_reset,
  output logic             running,
  output logic             done,
  output logic             timeout,
  output logic [1:0]       halt_code,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] retired_count,
  output logic [XLEN-1:0]  final_pc
);

  localparam int unsigned RST_W  = $clog2(RST_CYCLES + 1);
  localparam int unsigned LOOP_W = $clog2(LOOP_REPEAT + 1);

  state_t            state_q, state_d;
  logic [RST_W-1:0]  rst_cnt_q, rst_cnt_d;
  logic [LOOP_W-1:0] loop_cnt_q, loop_cnt_d, loop_next;
  logic [XLEN-1:0]   prev_pc_q, prev_pc_d;
  logic [XLEN-1:0]   final_pc_q, final_pc_d;
  logic [1:0]        halt_code_q, halt_code_d;
  logic              timeout_q, timeout_d;
  logic              cpu_reset_q, cpu_reset_d;
  logic              running_q, running_d;
  logic              done_q, done_d;
  logic              cnt_clr, cyc_en, ret_en;
  logic              pc_same, loop_hit, cyc_last;
  logic [CNT_W-1:0]  cycle_cnt_w, retired_cnt_w;

  // Halt/timeout conditions for the current RUN cycle.
  assign pc_same   = (pc_in == prev_pc_q);
  assign loop_next = loop_cnt_q + LOOP_W'(1);
  assign loop_hit  = pc_same && (loop_next == LOOP_W'(LOOP_REPEAT));
  assign cyc_last  = ({1'b0, cycle_cnt_w} + (CNT_W+1)'(1)) == (CNT_W+1)'(MAX_CYCLES);

  // Next-state and result logic.
  always_comb begin
    state_d     = state_q;
    rst_cnt_d   = rst_cnt_q;
    loop_cnt_d  = loop_cnt_q;
    prev_pc_d   = prev_pc_q;
    final_pc_d  = final_pc_q;
    halt_code_d = halt_code_q;
    timeout_d   = timeout_q;
    cnt_clr     = 1'b0;
    cyc_en      = 1'b0;
    ret_en      = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d     = RST_HOLD;
          rst_cnt_d   = RST_W'(RST_CYCLES);
          loop_cnt_d  = '0;
          prev_pc_d   = '0;
          final_pc_d  = '0;
          halt_code_d = HALT_NONE;
          timeout_d   = 1'b0;
          cnt_clr     = 1'b1;
        end
      end
      RST_HOLD: begin
        if (rst_cnt_q <= RST_W'(1)) begin
          state_d = RUN;
        end else begin
          rst_cnt_d = rst_cnt_q - RST_W'(1);
        end
      end
      RUN: begin
        cyc_en     = 1'b1;
        ret_en     = reg_we;
        prev_pc_d  = pc_in;
        loop_cnt_d = pc_same ? loop_next : '0;
        if (instr_in == INSTR_ECALL) begin
          state_d     = DONE;
          halt_code_d = HALT_ECALL;
          final_pc_d  = pc_in;
        end else if (instr_in == INSTR_EBREAK) begin
          state_d     = DONE;
          halt_code_d = HALT_EBREAK;
          final_pc_d  = pc_in;
        end else if (loop_hit) begin
          state_d     = DONE;
          halt_code_d = HALT_LOOP;
          final_pc_d  = pc_in;
        end else if (cyc_last) begin
          state_d     = DONE;
          halt_code_d = HALT_NONE;
          timeout_d   = 1'b1;
          final_pc_d  = pc_in;
        end
      end
      default: state_d = IDLE;
    endcase

    cpu_reset_d = (state_d != RUN);
    running_d   = (state_d == RUN);
    done_d      = (state_d == DONE);
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      rst_cnt_q   <= '0;
      loop_cnt_q  <= '0;
      prev_pc_q   <= '0;
      final_pc_q  <= '0;
      halt_code_q <= HALT_NONE;
      timeout_q   <= 1'b0;
      cpu_reset_q <= 1'b1;
      running_q   <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rst_cnt_q   <= rst_cnt_d;
      loop_cnt_q  <= loop_cnt_d;
      prev_pc_q   <= prev_pc_d;
      final_pc_q  <= final_pc_d;
      halt_code_q <= halt_code_d;
      timeout_q   <= timeout_d;
      cpu_reset_q <= cpu_reset_d;
      running_q   <= running_d;
      done_q      <= done_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .en    (cyc_en),
    .count (cycle_cnt_w)
  );

  sat_counter #(.W(CNT_W)) u_retired_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .en    (ret_en),
    .count (retired_cnt_w)
  );

  assign cpu_reset     = cpu_reset_q;
  assign running       = running_q;
  assign done          = done_q;
  assign timeout       = timeout_q;
  assign halt_code     = halt_code_q;
  assign cycle_count   = cycle_cnt_w;
  assign retired_count = retired_cnt_w;
  assign final_pc      = final_pc_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl with a run-result scoreboard.
module tb_cpu_run_ctrl;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned RST_C  = 3;
  localparam int unsigned MAX_C  = 24;
  localparam int unsigned LOOP_R = 2;

  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] ECALL  = 32'h0000_0073;
  localparam logic [31:0] EBREAK = 32'h0010_0073;

  typedef struct packed {
    logic [1:0]  halt;
    logic        to;
    logic [15:0] cyc;
    logic [15:0] ret;
    logic [31:0] pc;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [XLEN-1:0]  pc_in;
  logic [31:0]      instr_in;
  logic             reg_we;
  logic             cpu_reset;
  logic             running;
  logic             done;
  logic             timeout;
  logic [1:0]       halt_code;
  logic [CNT_W-1:0] cycle_count;
  logic [CNT_W-1:0] retired_count;
  logic [XLEN-1:0]  final_pc;

  int   vectors = 0;
  int   miscompares = 0;
  exp_t sb_q[$];
  exp_t e;
  int   ret_model;

  cpu_run_ctrl #(
    .XLEN(XLEN), .CNT_W(CNT_W), .RST_CYCLES(RST_C),
    .MAX_CYCLES(MAX_C), .LOOP_REPEAT(LOOP_R)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .pc_in(pc_in),
    .instr_in(instr_in), .reg_we(reg_we), .cpu_reset(cpu_reset),
    .running(running), .done(done), .timeout(timeout),
    .halt_code(halt_code), .cycle_count(cycle_count),
    .retired_count(retired_count), .final_pc(final_pc)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_cycle(input logic [31:0] pc, input logic [31:0] ins, input logic we);
    pc_in    = pc;
    instr_in = ins;
    reg_we   = we;
    tick();
  endtask

  // Pulse start, then sit through the reset hold until the core is released.
  task automatic start_run();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("hold_entry_cpu_reset", 32'(cpu_reset), 32'd1);
    for (int i = 0; i < int'(RST_C); i++) tick();
    check("hold_release_running", 32'(running), 32'd1);
  endtask

  // Wait (bounded) for DONE, then compare results against the oldest expectation.
  task automatic finish_run(input string tag);
    exp_t x;
    int   k;
    instr_in = NOP;
    reg_we   = 1'b0;
    k = 0;
    while (!done && k < 40) begin
      tick();
      k++;
    end
    check({tag, "_done"}, 32'(done), 32'd1);
    if (sb_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      x = sb_q.pop_front();
      check({tag, "_halt_code"}, 32'(halt_code), 32'(x.halt));
      check({tag, "_timeout"},   32'(timeout),   32'(x.to));
      check({tag, "_cycles"},    32'(cycle_count), 32'(x.cyc));
      check({tag, "_retired"},   32'(retired_count), 32'(x.ret));
      check({tag, "_final_pc"},  final_pc,         x.pc);
      check({tag, "_cpu_reset"}, 32'(cpu_reset),   32'd1);
      check({tag, "_running"},   32'(running),     32'd0);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; pc_in = '0; instr_in = NOP; reg_we = 1'b0;

    // Reset / idle
    tick(); tick();
    check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    check("rst_done",      32'(done), 32'd0);
    check("rst_running",   32'(running), 32'd0);
    check("rst_cycles",    32'(cycle_count), 32'd0);
    check("rst_halt_code", 32'(halt_code), 32'd0);
    check("rst_final_pc",  final_pc, 32'd0);
    reset = 1'b0;
    tick();
    check("idle_cpu_reset", 32'(cpu_reset), 32'd1);

    // Reset hold timing, cycle by cycle
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < int'(RST_C); i++) begin
      check($sformatf("hold_cyc%0d_cpu_reset", i), 32'(cpu_reset), 32'd1);
      check($sformatf("hold_cyc%0d_running", i), 32'(running), 32'd0);
      tick();
    end
    check("hold_end_cpu_reset", 32'(cpu_reset), 32'd0);
    check("hold_end_running",   32'(running), 32'd1);

    // ECALL on the 5th RUN cycle, writebacks on cycles 1, 2, 4
    e = '{halt: 2'd1, to: 1'b0, cyc: 16'd5, ret: 16'd3, pc: 32'h110};
    sb_q.push_back(e);
    run_cycle(32'h100, NOP, 1'b1);
    run_cycle(32'h104, NOP, 1'b1);
    run_cycle(32'h108, NOP, 1'b0);
    run_cycle(32'h10C, NOP, 1'b1);
    check("ecall_pre_done", 32'(done), 32'd0);
    run_cycle(32'h110, ECALL, 1'b0);
    finish_run("ecall");

    // Self-loop: 0x10 held for 3 cycles
    start_run();
    check("restart_cleared_cycles", 32'(cycle_count), 32'd0);
    check("restart_cleared_halt",   32'(halt_code), 32'd0);
    e = '{halt: 2'd3, to: 1'b0, cyc: 16'd4, ret: 16'd4, pc: 32'h10};
    sb_q.push_back(e);
    run_cycle(32'h0C, NOP, 1'b1);
    run_cycle(32'h10, NOP, 1'b1);
    run_cycle(32'h10, NOP, 1'b1);
    check("loop_pre_done", 32'(done), 32'd0);
    run_cycle(32'h10, NOP, 1'b1);
    finish_run("loop");

    // PC 0 on the first RUN cycle counts as a repeat of the cleared prev_pc
    start_run();
    e = '{halt: 2'd3, to: 1'b0, cyc: 16'd2, ret: 16'd0, pc: 32'h0};
    sb_q.push_back(e);
    run_cycle(32'h0, NOP, 1'b0);
    run_cycle(32'h0, NOP, 1'b0);
    finish_run("loop_pc0");

    // Timeout after MAX_CYCLES straight-line cycles
    start_run();
    ret_model = 0;
    for (int i = 0; i < int'(MAX_C); i++) begin
      if (i == int'(MAX_C) - 1) check("timeout_pre_done", 32'(done), 32'd0);
      ret_model += i % 2;
      run_cycle(32'h200 + 32'(4 * i), NOP, 1'(i % 2));
    end
    e = '{halt: 2'd0, to: 1'b1, cyc: 16'(MAX_C), ret: 16'(ret_model),
          pc: 32'h200 + 32'(4 * (MAX_C - 1))};
    sb_q.push_back(e);
    finish_run("timeout");

    // EBREAK on the timeout cycle: halt wins, timeout stays low
    start_run();
    for (int i = 0; i < int'(MAX_C); i++) begin
      run_cycle(32'h200 + 32'(4 * i), (i == int'(MAX_C) - 1) ? EBREAK : NOP, 1'b0);
    end
    e = '{halt: 2'd2, to: 1'b0, cyc: 16'(MAX_C), ret: 16'd0,
          pc: 32'h200 + 32'(4 * (MAX_C - 1))};
    sb_q.push_back(e);
    finish_run("ebreak_at_max");

    // Mid-run reset on RUN cycle 7, with a stray start during RUN
    start_run();
    for (int i = 0; i < 6; i++) begin
      start = (i == 2);
      run_cycle(32'h400 + 32'(4 * i), NOP, 1'b1);
    end
    start = 1'b0;
    check("run_start_ignored_cycles",  32'(cycle_count), 32'd6);
    check("run_start_ignored_running", 32'(running), 32'd1);
    reset = 1'b1;
    run_cycle(32'h418, NOP, 1'b1);
    reset = 1'b0;
    check("midrst_cpu_reset", 32'(cpu_reset), 32'd1);
    check("midrst_running",   32'(running), 32'd0);
    check("midrst_done",      32'(done), 32'd0);
    check("midrst_cycles",    32'(cycle_count), 32'd0);
    check("midrst_retired",   32'(retired_count), 32'd0);
    tick();
    check("midrst_idle_running", 32'(running), 32'd0);

    // Short run to DONE, then restart from DONE clears results
    start_run();
    e = '{halt: 2'd1, to: 1'b0, cyc: 16'd1, ret: 16'd1, pc: 32'h500};
    sb_q.push_back(e);
    run_cycle(32'h500, ECALL, 1'b1);
    finish_run("short");
    start = 1'b1;
    tick();
    start = 1'b0;
    check("redo_done",      32'(done), 32'd0);
    check("redo_cpu_reset", 32'(cpu_reset), 32'd1);
    check("redo_cycles",    32'(cycle_count), 32'd0);
    check("redo_retired",   32'(retired_count), 32'd0);
    check("redo_halt_code", 32'(halt_code), 32'd0);
    check("redo_final_pc",  final_pc, 32'd0);
    tick();
    check("redo_still_hold", 32'(running), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
